iic_send_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one iic_send byte-write engine between N_REQ requesters.
- Each requester presents a single-register write: 7-bit device address, 8-bit register address, 8-bit data.
- The arbiter grants one requester, loads its operands into the engine, starts the engine, waits for completion, and returns a per-requester done pulse.
- Sits between system-level clients (init sequencer, config registers, soft CPU bridge) and iic_send.

---
 rtl/iic_send_arbiter.sv | 173 +++++++++++++++++
 tb/tb_iic_send_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_send_arbiter.sv
// Round-robin arbiter sharing one iic_send byte-write engine; 1 cycle IDLE->start, done 1 cycle after engine done.
// Requesters hold req_valid until done/err; optional WAIT timeout under IIC_ARB_TIMEOUT_EN.
module iic_send_arbiter #(
    parameter int N_REQ = 4
`ifdef IIC_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 200000
`endif
) (
    input  logic                 sys_clk,
    input  logic                 sys_reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [7*N_REQ-1:0]   req_dev_addr,
    input  logic [8*N_REQ-1:0]   req_reg_addr,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_done,
    output logic [N_REQ-1:0]     req_err,
    output logic                 arb_busy,
    output logic [2:0]           arb_grant_id,
    output logic                 iic_send_en,
    output logic [6:0]           iic_device_addr,
    output logic [7:0]           iic_send_addr,
    output logic [7:0]           iic_send_data,
    input  logic                 iic_send_done
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

    state_t           state_q;
    logic [2:0]       rr_q;
    logic [2:0]       grant_q;
    logic             busy_q;
    logic             en_q;
    logic [6:0]       dev_q;
    logic [7:0]       addr_q;
    logic [7:0]       data_q;
    logic [N_REQ-1:0] done_q;

    logic [2*N_REQ-1:0] rot;
    logic               pick_vld;
    logic [2:0]         pick_idx;
    logic [3:0]         pos;
    logic [6:0]         dev_sel;
    logic [7:0]         addr_sel;
    logic [7:0]         data_sel;
    logic [3:0]         rr_inc;
    logic [2:0]         rr_d;
    logic [N_REQ-1:0]   grant_oh;

    // Rotate so bit 0 is rr_q; scanning downward leaves the lowest offset as the winner.
    always_comb begin
        rot      = {req_valid, req_valid} >> rr_q;
        pick_vld = 1'b0;
        pick_idx = 3'd0;
        pos      = 4'd0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick_vld = 1'b1;
                pos      = {1'b0, rr_q} + 4'(k);
                if (pos >= 4'(N_REQ)) begin
                    pos = pos - 4'(N_REQ);
                end
                pick_idx = pos[2:0];
            end
        end
    end

    always_comb begin
        dev_sel  = 7'd0;
        addr_sel = 8'd0;
        data_sel = 8'd0;
        for (int j = 0; j < N_REQ; j++) begin
            if (3'(j) == pick_idx) begin
                dev_sel  = req_dev_addr[7*j +: 7];
                addr_sel = req_reg_addr[8*j +: 8];
                data_sel = req_data[8*j +: 8];
            end
        end
    end

    always_comb begin
        rr_inc   = {1'b0, grant_q} + 4'd1;
        rr_d     = (rr_inc >= 4'(N_REQ)) ? 3'd0 : rr_inc[2:0];
        grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
    end

`ifdef IIC_ARB_TIMEOUT_EN
    logic [31:0]      cnt_q;
    logic [N_REQ-1:0] err_q;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q <= S_IDLE;
            rr_q    <= 3'd0;
            grant_q <= 3'd0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            dev_q   <= 7'd0;
            addr_q  <= 8'd0;
            data_q  <= 8'd0;
            done_q  <= '0;
`ifdef IIC_ARB_TIMEOUT_EN
            cnt_q   <= 32'd0;
            err_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick_idx;
                        dev_q   <= dev_sel;
                        addr_q  <= addr_sel;
                        data_q  <= data_sel;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    en_q <= 1'b0;
`ifdef IIC_ARB_TIMEOUT_EN
                    cnt_q <= 32'd0;
`endif
                    if (iic_send_done) begin
                        done_q  <= grant_oh;
                        state_q <= S_RELEASE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (iic_send_done) begin
                        done_q  <= grant_oh;
                        state_q <= S_RELEASE;
                    end
`ifdef IIC_ARB_TIMEOUT_EN
                    else if (cnt_q == 32'(TIMEOUT_CYCLES) - 32'd1) begin
                        err_q   <= grant_oh;
                        state_q <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
`endif
                end
                S_RELEASE: begin
                    done_q  <= '0;
`ifdef IIC_ARB_TIMEOUT_EN
                    err_q   <= '0;
`endif
                    rr_q    <= rr_d;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_done        = done_q;
    assign arb_busy        = busy_q;
    assign arb_grant_id    = grant_q;
    assign iic_send_en     = en_q;
    assign iic_device_addr = dev_q;
    assign iic_send_addr   = addr_q;
    assign iic_send_data   = data_q;
`ifdef IIC_ARB_TIMEOUT_EN
    assign req_err         = err_q;
`else
    assign req_err         = '0;
`endif

endmodule

// File: tb/tb_iic_send_arbiter.sv
// Directed bench for iic_send_arbiter: single write, round-robin, operand hold, reset abort, early done, wrap, timeout.
module tb_iic_send_arbiter;

    localparam int N = 4;

    logic           sys_clk = 1'b0;
    logic           sys_reset;
    logic [N-1:0]   req_valid;
    logic [7*N-1:0] req_dev_addr;
    logic [8*N-1:0] req_reg_addr;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_done;
    logic [N-1:0]   req_err;
    logic           arb_busy;
    logic [2:0]     arb_grant_id;
    logic           iic_send_en;
    logic [6:0]     iic_device_addr;
    logic [7:0]     iic_send_addr;
    logic [7:0]     iic_send_data;
    logic           iic_send_done;

    int tests = 0;
    int fails = 0;

    iic_send_arbiter #(
        .N_REQ(N)
`ifdef IIC_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(50)
`endif
    ) dut (
        .sys_clk(sys_clk),
        .sys_reset(sys_reset),
        .req_valid(req_valid),
        .req_dev_addr(req_dev_addr),
        .req_reg_addr(req_reg_addr),
        .req_data(req_data),
        .req_done(req_done),
        .req_err(req_err),
        .arb_busy(arb_busy),
        .arb_grant_id(arb_grant_id),
        .iic_send_en(iic_send_en),
        .iic_device_addr(iic_device_addr),
        .iic_send_addr(iic_send_addr),
        .iic_send_data(iic_send_data),
        .iic_send_done(iic_send_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_done"}, 32'(req_done), 32'd0);
        check({tag, "_err"},  32'(req_err), 32'd0);
        check({tag, "_busy"}, 32'(arb_busy), 32'd0);
        check({tag, "_gid"},  32'(arb_grant_id), 32'd0);
        check({tag, "_en"},   32'(iic_send_en), 32'd0);
        check({tag, "_dev"},  32'(iic_device_addr), 32'd0);
        check({tag, "_reg"},  32'(iic_send_addr), 32'd0);
        check({tag, "_dat"},  32'(iic_send_data), 32'd0);
    endtask

    // Runs one transaction from IDLE with all requesters valid; engine finishes after one WAIT cycle.
    task automatic rr_txn(input int exp_id);
        tick();
        check("rr_gid", 32'(arb_grant_id), 32'(exp_id));
        check("rr_en",  32'(iic_send_en), 32'd1);
        tick();
        iic_send_done = 1'b1;
        tick();
        iic_send_done = 1'b0;
        check("rr_done", 32'(req_done), 32'(4'b0001 << exp_id));
        tick();
        check("rr_idle", 32'(arb_busy), 32'd0);
    endtask

    initial begin
        sys_reset     = 1'b1;
        req_valid     = '0;
        req_dev_addr  = '0;
        req_reg_addr  = '0;
        req_data      = '0;
        iic_send_done = 1'b0;
        tick();
        tick();
        check_idle_zero("reset");
        sys_reset = 1'b0;
        tick();
        check_idle_zero("post_reset");

        // Single request on requester 1
        req_dev_addr[7*1 +: 7] = 7'h57;
        req_reg_addr[8*1 +: 8] = 8'h01;
        req_data[8*1 +: 8]     = 8'haa;
        req_valid = 4'b0010;
        tick();
        check("s_en",   32'(iic_send_en), 32'd1);
        check("s_gid",  32'(arb_grant_id), 32'd1);
        check("s_dev",  32'(iic_device_addr), 32'h57);
        check("s_reg",  32'(iic_send_addr), 32'h01);
        check("s_dat",  32'(iic_send_data), 32'haa);
        check("s_busy", 32'(arb_busy), 32'd1);
        tick();
        check("s_en_once", 32'(iic_send_en), 32'd0);
        tick();
        check("s_wait_done", 32'(req_done), 32'd0);
        iic_send_done = 1'b1;
        tick();
        iic_send_done = 1'b0;
        check("s_done", 32'(req_done), 32'(4'b0010));
        req_valid = 4'b0000;
        tick();
        check("s_done_pulse", 32'(req_done), 32'd0);
        check("s_busy_low",   32'(arb_busy), 32'd0);
        iic_send_done = 1'b1;
        tick();
        iic_send_done = 1'b0;
        check("idle_done_ign",  32'(req_done), 32'd0);
        check("idle_busy_ign",  32'(arb_busy), 32'd0);
        check("idle_keep_dat",  32'(iic_send_data), 32'haa);

        // Round-robin from a fresh reset
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            rr_txn(t % 4);
        end
        req_valid = 4'b0000;
        tick();

        // Operand stability, from reset so requester 0 wins
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        req_data[8*0 +: 8] = 8'h11;
        req_valid = 4'b0001;
        tick();
        check("op_dat_issue", 32'(iic_send_data), 32'h11);
        tick();
        req_data[8*0 +: 8] = 8'h22;
        tick();
        tick();
        check("op_dat_wait", 32'(iic_send_data), 32'h11);
        iic_send_done = 1'b1;
        tick();
        iic_send_done = 1'b0;
        check("op_done",     32'(req_done), 32'(4'b0001));
        check("op_dat_rel",  32'(iic_send_data), 32'h11);
        req_valid = 4'b0000;
        tick();

        // Reset in WAIT aborts; requester 2 granted first
        req_valid = 4'b0100;
        tick();
        check("mid_gid", 32'(arb_grant_id), 32'd2);
        tick();
        sys_reset = 1'b1;
        tick();
        check_idle_zero("mid_reset");
        sys_reset = 1'b0;
        req_valid = 4'b0101;
        tick();
        check("mid_gid0", 32'(arb_grant_id), 32'd0);
        check("mid_en",   32'(iic_send_en), 32'd1);

        // Early done in the ISSUE cycle
        iic_send_done = 1'b1;
        tick();
        iic_send_done = 1'b0;
        check("early_done", 32'(req_done), 32'(4'b0001));
        check("early_busy", 32'(arb_busy), 32'd1);
        req_valid = 4'b0100;
        tick();
        check("early_idle", 32'(arb_busy), 32'd0);
        check("early_dpul", 32'(req_done), 32'd0);
        tick();
        check("next_gid2", 32'(arb_grant_id), 32'd2);
        iic_send_done = 1'b1;
        tick();
        iic_send_done = 1'b0;
        check("g2_done", 32'(req_done), 32'(4'b0100));
        req_valid = 4'b0000;
        tick();

        // Pointer now 3: requesters 0 and 1 pending -> wrap to 0
        req_valid = 4'b0011;
        tick();
        check("wrap_gid", 32'(arb_grant_id), 32'd0);
        tick();
        iic_send_done = 1'b1;
        tick();
        iic_send_done = 1'b0;
        check("wrap_done", 32'(req_done), 32'(4'b0001));
        req_valid = 4'b0000;
        tick();

`ifdef IIC_ARB_TIMEOUT_EN
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        req_valid = 4'b1000;
        tick();
        check("to_gid", 32'(arb_grant_id), 32'd3);
        tick();
        for (int w = 0; w < 49; w++) begin
            tick();
        end
        check("to_err_early", 32'(req_err), 32'd0);
        check("to_busy_wait", 32'(arb_busy), 32'd1);
        req_valid = 4'b0000;
        tick();
        check("to_err",   32'(req_err), 32'(4'b1000));
        check("to_done0", 32'(req_done), 32'd0);
        check("to_busy",  32'(arb_busy), 32'd1);
        tick();
        check("to_busy_low", 32'(arb_busy), 32'd0);
        check("to_err_pul",  32'(req_err), 32'd0);
        iic_send_done = 1'b1;
        tick();
        iic_send_done = 1'b0;
        tick();
        check("to_late_done", 32'(req_done), 32'd0);
        check("to_late_busy", 32'(arb_busy), 32'd0);
`else
        check("err_tied", 32'(req_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
